keypad_matrix_scan: RTL
=======================

KEYPAD_MATRIX_SCAN -- requirements
Module: keypad_matrix_scan

Interface
REQ-001 Parameter ROWS, default 4, number of active-low row inputs (2..8).
REQ-002 Parameter COLS, default 3, number of driven columns (2..8).
REQ-003 Parameter SETTLE_CYCLES, default 4, cycles after a column change before rows are sampled (>= 3).
REQ-004 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles for press or release acceptance (20 ms at 50 MHz).
REQ-005 Parameter REPEAT_EN, default 1, enables auto-repeat events.
REQ-006 Parameter REPEAT_DELAY, default 25_000_000, held cycles before first repeat.
REQ-007 Parameter REPEAT_RATE, default 5_000_000, cycles between later repeats.
REQ-008 Derived constant CODE_W = clog2(ROWS*COLS).
REQ-009 clk  input  1  system clock.
REQ-010 rst_n  input  1  reset, asynchronous, active-low.
REQ-011 row_n  input  ROWS  raw asynchronous rows, low = key closed.
REQ-012 col_n  output  COLS  one-cold column drive.
REQ-013 key_valid  output  1  one-cycle event strobe.
REQ-014 key_code  output  CODE_W  key index = row*COLS + col, stable until next event.
REQ-015 key_press  output  1  1 = press/repeat event, 0 = release event; qualified by key_valid.
REQ-016 key_repeat  output  1  1 = event is an auto-repeat; qualified by key_valid.
REQ-017 key_held  output  1  level, high from press event to release event.
REQ-018 multi_err  output  1  one-cycle pulse, more than one row low in the sampled column.

Function
REQ-019 row_n shall pass a 2-flop synchroniser; all decisions use the synchronised value.
REQ-020 FSM states: SCAN, DEB_P, HELD, DEB_R.
REQ-021 SCAN: after SETTLE_CYCLES on current column, sample rows; all high -> rotate col_n one position (bit COLS-1 wraps to bit 0), restart settle.
REQ-022 SCAN, exactly one row low -> latch row index and column, freeze col_n, enter DEB_P.
REQ-023 SCAN, two or more rows low -> multi_err pulse, rotate column, stay SCAN, no key event.
REQ-024 DEB_P: latched row must stay low and other rows high for DEBOUNCE_CYCLES; any deviation -> SCAN, rotate column, no event.
REQ-025 DEB_P complete -> next cycle key_valid=1, key_press=1, key_repeat=0, key_code updated, key_held=1; enter HELD.
REQ-026 HELD: latched row high -> DEB_R; other rows/columns ignored (no multi_err).
REQ-027 HELD with REPEAT_EN=1: repeat event (key_press=1, key_repeat=1, same key_code) after REPEAT_DELAY held cycles, then every REPEAT_RATE cycles; REPEAT_EN=0 -> none.
REQ-028 DEB_R: latched row high for DEBOUNCE_CYCLES -> key_valid=1, key_press=0, key_repeat=0, same key_code, key_held=0; rotate column; enter SCAN.
REQ-029 DEB_R: latched row low again before completion -> HELD, repeat timer restarted at REPEAT_DELAY, no event.
REQ-030 At most one key_valid per cycle; key_press, key_repeat, key_code change only with key_valid.
REQ-031 Counters shall be wide enough for the largest timing parameter and never wrap while counting.

Reset
REQ-032 rst_n low asynchronously forces: state SCAN, col_n with only bit 0 low, key_valid/key_press/key_repeat/key_held/multi_err 0, key_code 0, counters and synchroniser cleared.
REQ-033 Reset mid-HELD shall emit no release event; after reset deassertion the held key is re-detected as a new press.

Structure
REQ-034 Shared package keypad_pkg holds the state enum and the clog2 helper.
REQ-035 One sub-module kp_timer (loadable down-counter with terminal-count flag) serves settle, debounce and repeat timing.

Verification (DEBOUNCE_CYCLES=100, REPEAT_DELAY=1000, REPEAT_RATE=200, ROWS=4, COLS=3)
REQ-036 Hold row 1 low while column 2 driven, 500 cycles, release -> one press with key_code=5, one release with key_code=5, key_held high between.
REQ-037 Row 0 low 60 cycles in column 0 then high -> no key_valid, scanning resumes.
REQ-038 Hold key code 0 for 1700 cycles after press -> repeats at +1000, +1200, +1400, +1600 cycles; REPEAT_EN=0 -> none.
REQ-039 Rows 0 and 2 both low in column 1 -> multi_err pulse, no key_valid.
REQ-040 Release glitch of 50 cycles during HELD -> no release event, next repeat 1000 cycles after glitch end.
REQ-041 rst_n asserted during HELD -> outputs at reset values immediately, no release event, press re-reported after reset.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and elaboration-time helpers for the keypad matrix scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DEB_P = 2'd1,
        HELD  = 2'd2,
        DEB_R = 2'd3
    } kp_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kp_timer.sv
// Loadable down-counter with terminal-count flag. Holds at zero, never wraps.
module kp_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/keypad_matrix_scan.sv
// Keypad matrix scanner: rotates a one-cold column drive, debounces a single
// closed key, reports press / auto-repeat / release events, flags ghosting.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000,
    localparam int CODE_W         = clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   col_n,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_press,
    output logic              key_repeat,
    output logic              key_held,
    output logic              multi_err
);

    localparam int RW   = clog2(ROWS);
    localparam int CW   = clog2(COLS);
    localparam int TMAX = max2(max2(SETTLE_CYCLES, DEBOUNCE_CYCLES),
                               max2(REPEAT_DELAY, REPEAT_RATE));
    localparam int TW   = clog2(TMAX + 1);

    // Timer loads are N-1 so that the terminal count marks the Nth cycle.
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] DEB_LD    = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] RDLY_LD   = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RRATE_LD  = TW'(REPEAT_RATE - 1);

    kp_state_e         state_q, state_d;
    logic [CW-1:0]     col_q, col_d, col_next;
    logic [RW-1:0]     row_q, row_d;
    logic [ROWS-1:0]   sync1_q, sync2_q;
    logic              key_valid_q, key_valid_d;
    logic              key_press_q, key_press_d;
    logic              key_repeat_q, key_repeat_d;
    logic              key_held_q, key_held_d;
    logic              multi_err_q, multi_err_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;

    logic [3:0]        low_cnt;
    logic [RW-1:0]     low_idx;
    logic [ROWS-1:0]   exp_rows;
    logic [CODE_W-1:0] cur_code;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_tc;

    kp_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // Two-flop synchroniser for the raw rows. Resets to the released level so
    // the first sample after reset cannot look like a ghosted multi-key press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
        end
    end

    // Row decode: count of closed rows, index of a closed row, and the
    // pattern expected while only the latched row is closed.
    always_comb begin
        low_cnt  = '0;
        low_idx  = '0;
        exp_rows = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!sync2_q[r]) begin
                low_cnt = low_cnt + 1'b1;
                low_idx = RW'(r);
            end
            if (row_q == RW'(r)) exp_rows[r] = 1'b0;
        end
    end

    assign col_next = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    assign cur_code = CODE_W'(int'(row_q) * COLS + int'(col_q));

    // Next-state and event logic.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        key_valid_d  = 1'b0;
        key_press_d  = key_press_q;
        key_repeat_d = key_repeat_q;
        key_code_d   = key_code_q;
        key_held_d   = key_held_q;
        multi_err_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = SETTLE_LD;
        case (state_q)
            SCAN: begin
                if (tmr_tc) begin
                    if (low_cnt == 4'd1) begin
                        row_d    = low_idx;
                        state_d  = DEB_P;
                        tmr_load = 1'b1;
                        tmr_val  = DEB_LD;
                    end else begin
                        multi_err_d = (low_cnt != 4'd0);
                        col_d       = col_next;
                        tmr_load    = 1'b1;
                        tmr_val     = SETTLE_LD;
                    end
                end
            end
            DEB_P: begin
                if (sync2_q != exp_rows) begin
                    state_d  = SCAN;
                    col_d    = col_next;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else if (tmr_tc) begin
                    state_d      = HELD;
                    key_valid_d  = 1'b1;
                    key_press_d  = 1'b1;
                    key_repeat_d = 1'b0;
                    key_code_d   = cur_code;
                    key_held_d   = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = RDLY_LD;
                end
            end
            HELD: begin
                if (sync2_q[row_q]) begin
                    state_d  = DEB_R;
                    tmr_load = 1'b1;
                    tmr_val  = DEB_LD;
                end else if (tmr_tc && REPEAT_EN) begin
                    key_valid_d  = 1'b1;
                    key_press_d  = 1'b1;
                    key_repeat_d = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = RRATE_LD;
                end
            end
            DEB_R: begin
                if (!sync2_q[row_q]) begin
                    state_d  = HELD;
                    tmr_load = 1'b1;
                    tmr_val  = RDLY_LD;
                end else if (tmr_tc) begin
                    state_d      = SCAN;
                    key_valid_d  = 1'b1;
                    key_press_d  = 1'b0;
                    key_repeat_d = 1'b0;
                    key_held_d   = 1'b0;
                    col_d        = col_next;
                    tmr_load     = 1'b1;
                    tmr_val      = SETTLE_LD;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SCAN;
            col_q        <= '0;
            row_q        <= '0;
            key_valid_q  <= 1'b0;
            key_press_q  <= 1'b0;
            key_repeat_q <= 1'b0;
            key_code_q   <= '0;
            key_held_q   <= 1'b0;
            multi_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            key_valid_q  <= key_valid_d;
            key_press_q  <= key_press_d;
            key_repeat_q <= key_repeat_d;
            key_code_q   <= key_code_d;
            key_held_q   <= key_held_d;
            multi_err_q  <= multi_err_d;
        end
    end

    // One-cold column drive from the column index.
    always_comb begin
        col_n = '1;
        for (int c = 0; c < COLS; c++) begin
            if (col_q == CW'(c)) col_n[c] = 1'b0;
        end
    end

    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_press  = key_press_q;
    assign key_repeat = key_repeat_q;
    assign key_held   = key_held_q;
    assign multi_err  = multi_err_q;

endmodule
